// File: rtl/mem_pkg.sv
// Shared types for the memory-stage access controller and lane aligner.
package mem_pkg;

  localparam int LS_LB  = 0;
  localparam int LS_LH  = 1;
  localparam int LS_LW  = 2;
  localparam int LS_LD  = 3;
  localparam int LS_LBU = 4;
  localparam int LS_LHU = 5;
  localparam int LS_LWU = 6;
  localparam int LS_SB  = 7;
  localparam int LS_SH  = 8;
  localparam int LS_SW  = 9;
  localparam int LS_SD  = 10;
  localparam int LS_N   = 11;

  localparam logic [63:0] ALIGN_MASK = ~64'h7;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DONE
  } state_e;

  typedef enum logic [1:0] {
    SZ_B,
    SZ_H,
    SZ_W,
    SZ_D
  } size_e;

  typedef struct packed {
    logic  wen;
    logic  uns;
    size_e size;
  } op_t;

  function automatic logic misaligned(size_e sz, logic [2:0] off);
    logic m;
    unique case (sz)
      SZ_B: m = 1'b0;
      SZ_H: m = off[0];
      SZ_W: m = |off[1:0];
      SZ_D: m = |off;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: store strobes/data and extended load results.
module mem_lane_align
  import mem_pkg::*;
(
  input  op_t         op,
  input  logic [2:0]  off,
  input  logic [63:0] wdata,
  input  logic [63:0] rdata,
  output logic [7:0]  wstrb,
  output logic [63:0] wdata_lane,
  output logic [63:0] load_data
);

  logic [5:0]  sh;
  logic [63:0] rsh;
  logic        sx;

  assign sh         = {off, 3'b000};
  assign rsh        = rdata >> sh;
  assign wdata_lane = wdata << sh;
  assign sx         = ~op.uns;

  always_comb begin
    wstrb     = 8'h00;
    load_data = rsh;
    unique case (op.size)
      SZ_B: begin
        wstrb     = 8'h01 << off;
        load_data = {{56{sx & rsh[7]}}, rsh[7:0]};
      end
      SZ_H: begin
        wstrb     = 8'h03 << off;
        load_data = {{48{sx & rsh[15]}}, rsh[15:0]};
      end
      SZ_W: begin
        wstrb     = 8'h0F << off;
        load_data = {{32{sx & rsh[31]}}, rsh[31:0]};
      end
      SZ_D: begin
        wstrb     = 8'hFF;
      end
    endcase
    if (!op.wen) wstrb = 8'h00;
  end

endmodule

// File: rtl/mem_ctrl.sv
// Memory-stage controller: one bus transaction per load/store.
// MEM_CTRL_MISALIGN_TRAP_EN enables the misaligned-access trap.
module mem_ctrl
  import mem_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [LS_N-1:0]   mem_ctrl_i_load_store_info,
  input  logic [ADDR_W-1:0] mem_ctrl_i_addr,
  input  logic [DATA_W-1:0] mem_ctrl_i_wdata,
  output logic              mem_ctrl_o_req_valid,
  input  logic              mem_ctrl_i_req_ready,
  output logic [ADDR_W-1:0] mem_ctrl_o_req_addr,
  output logic              mem_ctrl_o_req_wen,
  output logic [7:0]        mem_ctrl_o_req_wstrb,
  output logic [DATA_W-1:0] mem_ctrl_o_req_wdata,
  input  logic              mem_ctrl_i_resp_valid,
  input  logic [DATA_W-1:0] mem_ctrl_i_resp_rdata,
  output logic              mem_ctrl_o_stall,
  output logic              mem_ctrl_o_done,
  output logic [DATA_W-1:0] mem_ctrl_o_load_data,
  output logic              mem_ctrl_o_err
);

  state_e            state, nxt;
  op_t               dec, op_q;
  logic [LS_N-1:0]   low;
  logic [2:0]        off_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, ld_q, la_load;
  logic              go, trap, err_q;

  // lowest set bit wins when several op bits are set
  assign low = mem_ctrl_i_load_store_info
             & (~mem_ctrl_i_load_store_info + 11'd1);
  assign go  = rst & (|mem_ctrl_i_load_store_info);

  always_comb begin
    dec = '0;
    unique case (1'b1)
      low[LS_LB]:  dec = '{1'b0, 1'b0, SZ_B};
      low[LS_LH]:  dec = '{1'b0, 1'b0, SZ_H};
      low[LS_LW]:  dec = '{1'b0, 1'b0, SZ_W};
      low[LS_LD]:  dec = '{1'b0, 1'b0, SZ_D};
      low[LS_LBU]: dec = '{1'b0, 1'b1, SZ_B};
      low[LS_LHU]: dec = '{1'b0, 1'b1, SZ_H};
      low[LS_LWU]: dec = '{1'b0, 1'b1, SZ_W};
      low[LS_SB]:  dec = '{1'b1, 1'b0, SZ_B};
      low[LS_SH]:  dec = '{1'b1, 1'b0, SZ_H};
      low[LS_SW]:  dec = '{1'b1, 1'b0, SZ_W};
      low[LS_SD]:  dec = '{1'b1, 1'b0, SZ_D};
      default:     dec = '0;
    endcase
  end

`ifdef MEM_CTRL_MISALIGN_TRAP_EN
  assign trap = misaligned(dec.size, mem_ctrl_i_addr[2:0]);
`else
  assign trap = 1'b0;
`endif

  always_comb begin
    nxt                  = state;
    mem_ctrl_o_stall     = 1'b0;
    mem_ctrl_o_req_valid = 1'b0;
    unique case (state)
      IDLE: begin
        if (go) begin
          mem_ctrl_o_stall = 1'b1;
          nxt = trap ? DONE : REQ;
        end
      end
      REQ: begin
        mem_ctrl_o_stall     = 1'b1;
        mem_ctrl_o_req_valid = 1'b1;
        if (mem_ctrl_i_req_ready) nxt = WAIT;
      end
      WAIT: begin
        mem_ctrl_o_stall = 1'b1;
        if (mem_ctrl_i_resp_valid) nxt = DONE;
      end
      DONE: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      op_q    <= '0;
      off_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      ld_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= nxt;
      err_q <= (state == IDLE) && go && trap;
      if (state == IDLE && go && !trap) begin
        addr_q  <= mem_ctrl_i_addr & ALIGN_MASK[ADDR_W-1:0];
        off_q   <= mem_ctrl_i_addr[2:0];
        op_q    <= dec;
        wdata_q <= mem_ctrl_i_wdata;
      end
      if (state == WAIT && mem_ctrl_i_resp_valid && !op_q.wen)
        ld_q <= la_load;
    end
  end

  mem_lane_align u_align (
    .op         (op_q),
    .off        (off_q),
    .wdata      (wdata_q),
    .rdata      (mem_ctrl_i_resp_rdata),
    .wstrb      (mem_ctrl_o_req_wstrb),
    .wdata_lane (mem_ctrl_o_req_wdata),
    .load_data  (la_load)
  );

  assign mem_ctrl_o_req_addr  = addr_q;
  assign mem_ctrl_o_req_wen   = op_q.wen;
  assign mem_ctrl_o_done      = (state == DONE);
  assign mem_ctrl_o_load_data = ld_q;
  assign mem_ctrl_o_err       = err_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl against a byte-level reference model.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] info;
  logic [63:0] addr, wdata;
  logic        req_valid, req_ready;
  logic [63:0] req_addr;
  logic        req_wen;
  logic [7:0]  req_wstrb;
  logic [63:0] req_wdata;
  logic        resp_valid;
  logic [63:0] resp_rdata;
  logic        stall, done, err;
  logic [63:0] load_data;

  int errors = 0;
  int checks = 0;

  int          o_stall, o_reqv, o_hs, o_done, o_cycles;
  bit          o_stable, o_timeout;
  logic        o_err, o_wen;
  logic [63:0] o_ld, o_addr, o_wdata;
  logic [7:0]  o_strb;
  logic [63:0] exp_ld;

  always #5 clk = ~clk;

  mem_ctrl dut (
    .clk                        (clk),
    .rst                        (rst),
    .mem_ctrl_i_load_store_info (info),
    .mem_ctrl_i_addr            (addr),
    .mem_ctrl_i_wdata           (wdata),
    .mem_ctrl_o_req_valid       (req_valid),
    .mem_ctrl_i_req_ready       (req_ready),
    .mem_ctrl_o_req_addr        (req_addr),
    .mem_ctrl_o_req_wen         (req_wen),
    .mem_ctrl_o_req_wstrb       (req_wstrb),
    .mem_ctrl_o_req_wdata       (req_wdata),
    .mem_ctrl_i_resp_valid      (resp_valid),
    .mem_ctrl_i_resp_rdata      (resp_rdata),
    .mem_ctrl_o_stall           (stall),
    .mem_ctrl_o_done            (done),
    .mem_ctrl_o_load_data       (load_data),
    .mem_ctrl_o_err             (err)
  );

  function automatic int nbytes(int idx);
    case (idx)
      0, 4, 7: return 1;
      1, 5, 8: return 2;
      2, 6, 9: return 4;
      default: return 8;
    endcase
  endfunction

  function automatic logic [63:0] m_load(int idx, int off, logic [63:0] rd);
    int n = nbytes(idx);
    logic [63:0] r = '0;
    for (int i = 0; i < n; i++)
      if (off + i < 8) r[8*i +: 8] = rd[8*(off+i) +: 8];
    if (idx <= 2 && r[8*n-1])
      for (int i = n; i < 8; i++) r[8*i +: 8] = 8'hFF;
    return r;
  endfunction

  function automatic logic [7:0] m_strb(int idx, int off);
    int n = nbytes(idx);
    logic [7:0] s = '0;
    if (n == 8) return 8'hFF;
    for (int i = 0; i < n; i++)
      if (off + i < 8) s[off+i] = 1'b1;
    return s;
  endfunction

  function automatic bit m_mis(int idx, int off);
    return (off % nbytes(idx)) != 0;
  endfunction

  task automatic do_access(input logic [10:0] inf, input logic [63:0] a,
                           input logic [63:0] wd, input logic [63:0] rd,
                           input int rdly, input int respdly);
    int cyc = 0;
    int hs_at = -1;
    int rv_wait = 0;
    bit fin = 0;
    o_stall = 0; o_reqv = 0; o_hs = 0; o_done = 0;
    o_stable = 1; o_timeout = 0; o_err = 0; o_ld = '0;
    o_addr = '0; o_wen = 0; o_strb = '0; o_wdata = '0;
    @(posedge clk); #1;
    info = inf; addr = a; wdata = wd; resp_rdata = rd;
    req_ready = 0; resp_valid = 0;
    while (!fin && cyc < 200) begin
      @(negedge clk);
      if (stall) o_stall++;
      if (done) begin
        o_done++; o_err = err; o_ld = load_data; fin = 1;
      end
      if (req_valid) begin
        if (o_reqv == 0) begin
          o_addr = req_addr; o_wen = req_wen;
          o_strb = req_wstrb; o_wdata = req_wdata;
        end else if (o_addr !== req_addr || o_wen !== req_wen ||
                     o_strb !== req_wstrb || o_wdata !== req_wdata) begin
          o_stable = 0;
        end
        o_reqv++;
        req_ready = (rv_wait >= rdly);
        rv_wait++;
        if (req_ready) begin o_hs++; hs_at = cyc; end
      end else begin
        req_ready = 0;
      end
      resp_valid = !fin && hs_at >= 0 && cyc > hs_at + respdly;
      cyc++;
    end
    o_cycles = cyc;
    o_timeout = !fin;
    @(posedge clk); #1;
    info = '0; req_ready = 0; resp_valid = 0;
  endtask

  task automatic test_reset();
    rst = 0; info = '0; addr = '0; wdata = '0;
    req_ready = 0; resp_valid = 0; resp_rdata = '0;
    #12;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", stall); end
    checks++; if (req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid: got %b want 0", req_valid); end
    checks++; if (done !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL reset_done_err: got %b%b want 00", done, err); end
    checks++; if (load_data !== 64'h0) begin errors++; $display("FAIL reset_load_data: got %h want 0", load_data); end
    checks++; if ({req_addr, req_wdata, req_wstrb, req_wen} !== '0) begin errors++; $display("FAIL reset_payload: got %h %h %h %b want 0", req_addr, req_wdata, req_wstrb, req_wen); end
    @(negedge clk); rst = 1;
    exp_ld = '0;
  endtask

  task automatic test_ld();
    do_access(11'h008, 64'h1000, 64'h0, 64'h1122334455667788, 0, 0);
    exp_ld = 64'h1122334455667788;
    checks++; if (o_timeout) begin errors++; $display("FAIL ld_timeout: got timeout want done"); end
    checks++; if (o_stall !== 3) begin errors++; $display("FAIL ld_stall_cycles: got %0d want 3", o_stall); end
    checks++; if (o_cycles !== 4) begin errors++; $display("FAIL ld_latency: got %0d want 4", o_cycles); end
    checks++; if (o_done !== 1) begin errors++; $display("FAIL ld_done: got %0d want 1", o_done); end
    checks++; if (o_ld !== exp_ld) begin errors++; $display("FAIL ld_data: got %h want %h", o_ld, exp_ld); end
    checks++; if (o_addr !== 64'h1000 || o_strb !== 8'h00 || o_wen !== 1'b0) begin errors++; $display("FAIL ld_req: got %h %h %b want 1000 00 0", o_addr, o_strb, o_wen); end
  endtask

  task automatic test_lb_lbu();
    do_access(11'h001, 64'h1003, 64'h0, 64'h0000000080000000, 0, 1);
    checks++; if (o_ld !== 64'hFFFFFFFFFFFFFF80) begin errors++; $display("FAIL lb_sext: got %h want ffffffffffffff80", o_ld); end
    checks++; if (o_addr !== 64'h1000) begin errors++; $display("FAIL lb_addr: got %h want 1000", o_addr); end
    do_access(11'h010, 64'h1003, 64'h0, 64'h0000000080000000, 1, 0);
    exp_ld = 64'h80;
    checks++; if (o_ld !== exp_ld) begin errors++; $display("FAIL lbu_zext: got %h want 80", o_ld); end
  endtask

  task automatic test_sh();
    do_access(11'h100, 64'h2006, 64'hABCD, 64'h0, 0, 0);
    checks++; if (o_wen !== 1'b1) begin errors++; $display("FAIL sh_wen: got %b want 1", o_wen); end
    checks++; if (o_strb !== 8'hC0) begin errors++; $display("FAIL sh_wstrb: got %h want c0", o_strb); end
    checks++; if (o_wdata !== 64'hABCD000000000000) begin errors++; $display("FAIL sh_wdata: got %h want abcd000000000000", o_wdata); end
    checks++; if (o_addr !== 64'h2000) begin errors++; $display("FAIL sh_addr: got %h want 2000", o_addr); end
  endtask

  task automatic test_backpressure();
    do_access(11'h200, 64'h3004, 64'h0000000012345678, 64'h0, 5, 0);
    checks++; if (o_reqv !== 6) begin errors++; $display("FAIL bp_req_cycles: got %0d want 6", o_reqv); end
    checks++; if (!o_stable) begin errors++; $display("FAIL bp_payload_stable: got changed want stable"); end
    checks++; if (o_hs !== 1) begin errors++; $display("FAIL bp_handshakes: got %0d want 1", o_hs); end
    checks++; if (o_stall !== 8) begin errors++; $display("FAIL bp_stall_cycles: got %0d want 8", o_stall); end
    checks++; if (o_strb !== 8'hF0 || o_wdata !== 64'h1234567800000000) begin errors++; $display("FAIL bp_lanes: got %h %h want f0 1234567800000000", o_strb, o_wdata); end
  endtask

  task automatic test_reset_in_wait();
    @(posedge clk); #1;
    info = 11'h008; addr = 64'h3000; resp_rdata = 64'hDEADBEEFDEADBEEF;
    @(negedge clk);
    @(negedge clk);
    checks++; if (req_valid !== 1'b1) begin errors++; $display("FAIL rw_in_req: got %b want 1", req_valid); end
    req_ready = 1;
    @(negedge clk);
    req_ready = 0;
    checks++; if (stall !== 1'b1 || req_valid !== 1'b0) begin errors++; $display("FAIL rw_in_wait: got %b%b want 10", stall, req_valid); end
    rst = 0;
    #1;
    checks++; if ({stall, req_valid, done, err} !== 4'b0) begin errors++; $display("FAIL rw_ctrl_zero: got %b want 0000", {stall, req_valid, done, err}); end
    checks++; if (load_data !== 64'h0 || req_addr !== 64'h0) begin errors++; $display("FAIL rw_data_zero: got %h %h want 0 0", load_data, req_addr); end
    info = '0;
    exp_ld = '0;
    @(negedge clk); rst = 1;
    resp_valid = 1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++; if (done !== 1'b0 || load_data !== 64'h0) begin errors++; $display("FAIL rw_stale_resp: got %b %h want 0 0", done, load_data); end
    end
    resp_valid = 0;
    do_access(11'h008, 64'h3008, 64'h0, 64'h0102030405060708, 0, 2);
    exp_ld = 64'h0102030405060708;
    checks++; if (o_timeout || o_ld !== exp_ld) begin errors++; $display("FAIL rw_recover: got %h want %h", o_ld, exp_ld); end
  endtask

  task automatic test_misalign();
    logic [63:0] rd = 64'hCAFE_8765_4321_BEEF;
    do_access(11'h004, 64'h1002, 64'h0, rd, 0, 0);
`ifdef MEM_CTRL_MISALIGN_TRAP_EN
    checks++; if (o_reqv !== 0) begin errors++; $display("FAIL mis_no_req: got %0d want 0", o_reqv); end
    checks++; if (o_err !== 1'b1 || o_done !== 1) begin errors++; $display("FAIL mis_err_done: got %b %0d want 1 1", o_err, o_done); end
    checks++; if (o_stall !== 1) begin errors++; $display("FAIL mis_stall: got %0d want 1", o_stall); end
    checks++; if (o_ld !== exp_ld) begin errors++; $display("FAIL mis_ld_kept: got %h want %h", o_ld, exp_ld); end
`else
    exp_ld = 64'hFFFFFFFF87654321;
    checks++; if (o_hs !== 1 || o_strb !== 8'h00) begin errors++; $display("FAIL mis_req: got %0d %h want 1 00", o_hs, o_strb); end
    checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL mis_err: got %b want 0", o_err); end
    checks++; if (o_ld !== exp_ld) begin errors++; $display("FAIL mis_ld: got %h want %h", o_ld, exp_ld); end
`endif
  endtask

  task automatic test_multi_bit();
    do_access(11'h210, 64'h4005, 64'hFFFF, 64'h0000F10000000000, 0, 0);
    exp_ld = 64'hF1;
    checks++; if (o_wen !== 1'b0) begin errors++; $display("FAIL multi_wen: got %b want 0", o_wen); end
    checks++; if (o_ld !== exp_ld) begin errors++; $display("FAIL multi_ld: got %h want f1", o_ld); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 40; it++) begin
      int idx = $urandom_range(0, 10);
      logic [10:0] one = 11'd1 << idx;
      logic [10:0] above = ~((one << 1) - 11'd1);
      logic [10:0] inf = one;
      logic [63:0] a = {$urandom, $urandom};
      logic [63:0] wd = {$urandom, $urandom};
      logic [63:0] rd = {$urandom, $urandom};
      int rdly = $urandom_range(0, 3);
      int rsp = $urandom_range(0, 3);
      int off = int'(a[2:0]);
      bit st = (idx >= 7);
      bit mis;
      if ($urandom_range(0, 3) == 0) inf = inf | (11'($urandom) & above);
`ifdef MEM_CTRL_MISALIGN_TRAP_EN
      mis = m_mis(idx, off);
`else
      mis = 0;
`endif
      do_access(inf, a, wd, rd, rdly, rsp);
      checks++; if (o_timeout || o_done !== 1) begin errors++; $display("FAIL rnd%0d_done: got %0d want 1", it, o_done); end
      if (mis) begin
        checks++; if (o_reqv !== 0 || o_err !== 1'b1 || o_stall !== 1) begin errors++; $display("FAIL rnd%0d_trap: got %0d %b %0d want 0 1 1", it, o_reqv, o_err, o_stall); end
        checks++; if (o_ld !== exp_ld) begin errors++; $display("FAIL rnd%0d_trap_ld: got %h want %h", it, o_ld, exp_ld); end
      end else begin
        checks++; if (o_hs !== 1 || !o_stable || o_err !== 1'b0) begin errors++; $display("FAIL rnd%0d_hs: got %0d %b %b want 1 1 0", it, o_hs, o_stable, o_err); end
        checks++; if (o_stall !== 3 + rdly + rsp) begin errors++; $display("FAIL rnd%0d_stall: got %0d want %0d", it, o_stall, 3 + rdly + rsp); end
        checks++; if (o_addr !== {a[63:3], 3'b000} || o_wen !== st) begin errors++; $display("FAIL rnd%0d_addr: got %h %b want %h %b", it, o_addr, o_wen, {a[63:3], 3'b000}, st); end
        checks++; if (o_strb !== (st ? m_strb(idx, off) : 8'h00)) begin errors++; $display("FAIL rnd%0d_strb: got %h want %h", it, o_strb, st ? m_strb(idx, off) : 8'h00); end
        if (st) begin
          checks++; if (o_wdata !== (wd << (8 * off))) begin errors++; $display("FAIL rnd%0d_wdata: got %h want %h", it, o_wdata, wd << (8 * off)); end
        end else begin
          exp_ld = m_load(idx, off, rd);
          checks++; if (o_ld !== exp_ld) begin errors++; $display("FAIL rnd%0d_load: got %h want %h", it, o_ld, exp_ld); end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_ld();
    test_lb_lbu();
    test_sh();
    test_backpressure();
    test_reset_in_wait();
    test_misalign();
    test_multi_bit();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
